bin2bcd_seq: RTL and testbench

Sequential shift-and-add-3 (double-dabble) binary-to-BCD converter with valid/ready handshakes on input and output. Sits directly upstream of the seven-segment multiplexer stage. Replaces per-digit divide/modulo in that stage with a registered, per-digit BCD vector. One conversion in flight at a time; one iteration per clock.

---
 rtl/bin2bcd_seq.sv | 127 ++++++++++++
 tb/tb_bin2bcd_seq.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, valid/ready on both sides.
// Optional leading-zero blanking output enabled by BIN2BCD_LZB_EN.
module bin2bcd_seq #(
    parameter int BIN_W  = 12,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      in_bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  out_ovf
`ifdef BIN2BCD_LZB_EN
    ,
    output logic [DIGITS-1:0]     out_blank
`endif
);

    localparam int BW    = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int CW    = (BIN_W > 64) ? BIN_W : 64;

    function automatic logic [63:0] pow10m1(input int d);
        logic [63:0] p;
        p = 64'd1;
        for (int k = 0; k < d; k++) p = p * 64'd10;
        return p - 64'd1;
    endfunction

    localparam logic [CW-1:0] MAXV = CW'(pow10m1(DIGITS));

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             r_state;
    logic [BIN_W-1:0]   r_bin;
    logic [BW-1:0]      r_bcd;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf;

    logic [BW-1:0]       w_adj;
    logic [BW+BIN_W-1:0] w_shift;
    logic [BW-1:0]       w_result;
    logic                w_ovf_in;

    always_comb begin
        w_adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5)
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            else
                w_adj[4*i +: 4] = r_bcd[4*i +: 4];
        end
    end

    assign w_shift  = {w_adj, r_bin} << 1;
    assign w_result = r_ovf ? {DIGITS{4'h9}} : w_shift[BW+BIN_W-1:BIN_W];
    assign w_ovf_in = CW'(in_bin) > MAXV;
    assign in_ready = (r_state == IDLE);

`ifdef BIN2BCD_LZB_EN
    logic [DIGITS-1:0] w_blank;

    // A digit blanks only if it and every more significant digit are zero.
    always_comb begin
        logic v_zero;
        w_blank = '0;
        v_zero  = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            v_zero     = v_zero & (w_result[4*i +: 4] == 4'd0);
            w_blank[i] = v_zero;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_bin     <= '0;
            r_bcd     <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
            out_valid <= 1'b0;
            out_bcd   <= '0;
            out_ovf   <= 1'b0;
`ifdef BIN2BCD_LZB_EN
            out_blank <= '0;
`endif
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_bin   <= in_bin;
                        r_bcd   <= '0;
                        r_cnt   <= CNT_W'(BIN_W);
                        r_ovf   <= w_ovf_in;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_bcd <= w_shift[BW+BIN_W-1:BIN_W];
                    r_bin <= w_shift[BIN_W-1:0];
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state   <= DONE;
                        out_bcd   <= w_result;
                        out_ovf   <= r_ovf;
                        out_valid <= 1'b1;
`ifdef BIN2BCD_LZB_EN
                        out_blank <= w_blank;
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: default 12-bit instance plus a
// 14-bit instance for the overflow path; checks blanking when enabled.
module tb_bin2bcd_seq;

    logic        clk;
    logic        rst_n;

    logic        iv12, ir12, ov12, ordy12, ovf12;
    logic [11:0] ib12;
    logic [15:0] ob12;
    logic        iv14, ir14, ov14, ordy14, ovf14;
    logic [13:0] ib14;
    logic [15:0] ob14;
    logic [3:0]  blk12, blk14;

    int checks = 0;
    int errors = 0;

    bin2bcd_seq #(.BIN_W(12), .DIGITS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv12), .in_ready(ir12), .in_bin(ib12),
        .out_valid(ov12), .out_ready(ordy12),
        .out_bcd(ob12), .out_ovf(ovf12)
`ifdef BIN2BCD_LZB_EN
        , .out_blank(blk12)
`endif
    );

    bin2bcd_seq #(.BIN_W(14), .DIGITS(4)) dut14 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv14), .in_ready(ir14), .in_bin(ib14),
        .out_valid(ov14), .out_ready(ordy14),
        .out_bcd(ob14), .out_ovf(ovf14)
`ifdef BIN2BCD_LZB_EN
        , .out_blank(blk14)
`endif
    );

`ifndef BIN2BCD_LZB_EN
    assign blk12 = 4'b0000;
    assign blk14 = 4'b0000;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ref_bcd(input int v);
        logic [15:0] r;
        int t;
        if (v > 9999) return 16'h9999;
        r = '0;
        t = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [3:0] ref_blank(input int v);
        logic [3:0] b;
        int p;
        b = '0;
        p = 1;
        if (v > 9999) return b;
        for (int i = 1; i < 4; i++) begin
            p = p * 10;
            b[i] = (v < p);
        end
        return b;
    endfunction

    // Drives one full transaction and reports what the DUT produced.
    task automatic run_conv(input bit sel, input int v,
                            output logic [15:0] bcd, output logic ovf,
                            output logic [3:0] blk, output int lat,
                            output logic rdy_busy, output logic rdy_after);
        @(negedge clk);
        if (sel) begin iv14 = 1'b1; ib14 = v[13:0]; end
        else     begin iv12 = 1'b1; ib12 = v[11:0]; end
        @(posedge clk); #1;
        iv12 = 1'b0; iv14 = 1'b0;
        ib12 = 12'($urandom); ib14 = 14'($urandom);
        rdy_busy = sel ? ir14 : ir12;
        lat = 0;
        while (!(sel ? ov14 : ov12) && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        bcd = sel ? ob14 : ob12;
        ovf = sel ? ovf14 : ovf12;
        blk = sel ? blk14 : blk12;
        @(negedge clk);
        if (sel) ordy14 = 1'b1; else ordy12 = 1'b1;
        @(posedge clk); #1;
        ordy12 = 1'b0; ordy14 = 1'b0;
        rdy_after = sel ? ir14 : ir12;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ir12 !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", ir12); end
        checks++;
        if (ov12 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", ov12); end
        checks++;
        if (ob12 !== 16'h0000) begin errors++; $display("FAIL reset_out_bcd got %h want 0000", ob12); end
        checks++;
        if (ovf12 !== 1'b0 || ovf14 !== 1'b0) begin errors++; $display("FAIL reset_out_ovf got %b/%b want 0", ovf12, ovf14); end
        checks++;
        if (blk12 !== 4'b0000) begin errors++; $display("FAIL reset_blank got %b want 0000", blk12); end
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_zero;
        logic [15:0] b; logic o, rb, ra; logic [3:0] k; int lat;
        run_conv(0, 0, b, o, k, lat, rb, ra);
        checks++;
        if (b !== 16'h0000 || o !== 1'b0) begin errors++; $display("FAIL zero_value got %h/%b want 0000/0", b, o); end
        checks++;
        if (lat != 12) begin errors++; $display("FAIL zero_latency got %0d want 12", lat); end
    endtask

    task automatic test_max_then;
        logic [15:0] b; logic o, rb, ra; logic [3:0] k; int lat;
        int vals[2] = '{4095, 999};
        foreach (vals[n]) begin
            run_conv(0, vals[n], b, o, k, lat, rb, ra);
            checks++;
            if (b !== ref_bcd(vals[n]) || o !== 1'b0) begin
                errors++; $display("FAIL max_value v=%0d got %h/%b want %h/0", vals[n], b, o, ref_bcd(vals[n]));
            end
            checks++;
            if (rb !== 1'b0 || ra !== 1'b1) begin
                errors++; $display("FAIL max_in_ready busy=%b after=%b want 0/1", rb, ra);
            end
        end
    endtask

    task automatic test_random;
        logic [15:0] b; logic o, rb, ra; logic [3:0] k; int lat, v;
        for (int n = 0; n < 25; n++) begin
            v = int'($urandom_range(0, 4095));
            run_conv(0, v, b, o, k, lat, rb, ra);
            checks++;
            if (b !== ref_bcd(v) || o !== 1'b0 || lat != 12) begin
                errors++; $display("FAIL rand12 v=%0d got %h/%b lat %0d want %h/0 lat 12", v, b, o, lat, ref_bcd(v));
            end
`ifdef BIN2BCD_LZB_EN
            checks++;
            if (k !== ref_blank(v)) begin errors++; $display("FAIL rand_blank v=%0d got %b want %b", v, k, ref_blank(v)); end
`endif
        end
    endtask

    task automatic test_backpressure;
        int lat;
        @(negedge clk); iv12 = 1'b1; ib12 = 12'd123;
        @(posedge clk); #1;
        ib12 = 12'd7;
        lat = 0;
        while (!ov12 && lat < 200) begin @(posedge clk); #1; lat++; end
        checks++;
        if (ov12 !== 1'b1 || ob12 !== 16'h0123) begin errors++; $display("FAIL bp_result got %b/%h want 1/0123", ov12, ob12); end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++;
            if (ob12 !== 16'h0123 || ir12 !== 1'b0 || ov12 !== 1'b1) begin
                errors++; $display("FAIL bp_hold c=%0d got %h rdy=%b vld=%b want 0123/0/1", c, ob12, ir12, ov12);
            end
        end
        @(negedge clk) ordy12 = 1'b1;
        @(posedge clk); #1;
        ordy12 = 1'b0;
        checks++;
        if (ir12 !== 1'b1 || ov12 !== 1'b0 || ob12 !== 16'h0123) begin
            errors++; $display("FAIL bp_release got rdy=%b vld=%b bcd=%h want 1/0/0123", ir12, ov12, ob12);
        end
        @(posedge clk); #1;
        iv12 = 1'b0;
        checks++;
        if (ir12 !== 1'b0) begin errors++; $display("FAIL bp_accept got in_ready %b want 0", ir12); end
        lat = 0;
        while (!ov12 && lat < 200) begin @(posedge clk); #1; lat++; end
        checks++;
        if (ob12 !== 16'h0007 || lat != 12) begin errors++; $display("FAIL bp_next got %h lat %0d want 0007 lat 12", ob12, lat); end
        @(negedge clk) ordy12 = 1'b1;
        @(posedge clk); #1;
        ordy12 = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic [15:0] b; logic o, rb, ra; logic [3:0] k; int lat;
        @(negedge clk); iv12 = 1'b1; ib12 = 12'd555;
        @(posedge clk); #1;
        iv12 = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ov12 !== 1'b0 || ob12 !== 16'h0000 || ir12 !== 1'b1) begin
            errors++; $display("FAIL midrst got vld=%b bcd=%h rdy=%b want 0/0000/1", ov12, ob12, ir12);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        lat = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (ov12) lat++;
        end
        checks++;
        if (lat != 0) begin errors++; $display("FAIL midrst_no_result got %0d valid cycles want 0", lat); end
        run_conv(0, 42, b, o, k, lat, rb, ra);
        checks++;
        if (b !== 16'h0042) begin errors++; $display("FAIL midrst_next got %h want 0042", b); end
    endtask

    task automatic test_ovf14;
        logic [15:0] b; logic o, rb, ra; logic [3:0] k; int lat, v;
        int vals[6] = '{12345, 9999, 10000, 16383, 0, 1005};
        for (int n = 0; n < 16; n++) begin
            v = (n < 6) ? vals[n] : int'($urandom_range(0, 16383));
            run_conv(1, v, b, o, k, lat, rb, ra);
            checks++;
            if (b !== ref_bcd(v) || o !== (v > 9999) || lat != 14) begin
                errors++; $display("FAIL ovf14 v=%0d got %h/%b lat %0d want %h/%b lat 14", v, b, o, lat, ref_bcd(v), (v > 9999));
            end
`ifdef BIN2BCD_LZB_EN
            checks++;
            if (k !== ref_blank(v)) begin errors++; $display("FAIL ovf14_blank v=%0d got %b want %b", v, k, ref_blank(v)); end
`endif
        end
    endtask

`ifdef BIN2BCD_LZB_EN
    task automatic test_blank;
        logic [15:0] b; logic o, rb, ra; logic [3:0] k; int lat;
        int vals[3] = '{7, 0, 1005};
        logic [3:0] want[3] = '{4'b1110, 4'b1110, 4'b0000};
        foreach (vals[n]) begin
            run_conv(0, vals[n], b, o, k, lat, rb, ra);
            checks++;
            if (k !== want[n]) begin errors++; $display("FAIL blank v=%0d got %b want %b", vals[n], k, want[n]); end
        end
    endtask
`endif

    initial begin
        iv12 = 0; ib12 = 0; ordy12 = 0;
        iv14 = 0; ib14 = 0; ordy14 = 0;
        test_reset();
        test_zero();
        test_max_then();
        test_backpressure();
        test_random();
        test_reset_mid();
        test_ovf14();
`ifdef BIN2BCD_LZB_EN
        test_blank();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
